// File: rtl/instruction_fetch_unit.sv
// MIPS32 fetch stage: PC, synchronous I-mem addressing and the IF/ID register.
// Handles decode stalls by replaying the in-flight word and redirects with one bubble.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        ID_stall,
  input  logic        ID_PCSrc,
  input  logic [31:0] ID_new_PC,
  output logic [31:0] IM_Addr,
  input  logic [31:0] IM_Data,
  output logic [31:0] IF_ID_Instruction,
  output logic [31:0] IF_ID_PC4,
  output logic        IF_ID_Valid,
  output logic        Misaligned,
  output logic [31:0] Perf_Fetched,
  output logic [31:0] Perf_Redirects
);

  logic [31:0] pc;
  logic [31:0] f2_pc;
  logic        f2_v;
  logic        redirect;
  logic        replay;
  logic [31:0] target;

  assign redirect = ID_PCSrc & IF_ID_Valid & ~ID_stall;
  assign replay   = ID_stall & f2_v;
  assign target   = {ID_new_PC[31:2], 2'b00};

  always_comb begin
    IM_Addr = pc;
    unique case (1'b1)
      redirect: IM_Addr = target;
      replay:   IM_Addr = f2_pc;
      default:  IM_Addr = pc;
    endcase
  end

  // Front half: whatever address goes out this cycle becomes the in-flight word.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      pc    <= RESET_PC;
      f2_pc <= 32'h0;
      f2_v  <= 1'b0;
    end else if (!replay) begin
      pc    <= IM_Addr + 32'd4;
      f2_pc <= IM_Addr;
      f2_v  <= 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      IF_ID_Instruction <= 32'h0;
      IF_ID_PC4         <= 32'h0;
      IF_ID_Valid       <= 1'b0;
      Perf_Fetched      <= 32'h0;
      Perf_Redirects    <= 32'h0;
      Misaligned        <= 1'b0;
    end else if (redirect) begin
      IF_ID_Instruction <= 32'h0;
      IF_ID_Valid       <= 1'b0;
      Perf_Redirects    <= Perf_Redirects + 32'd1;
      if (ID_new_PC[1:0] != 2'b00)
        Misaligned <= 1'b1;
    end else if (!ID_stall) begin
      IF_ID_Instruction <= f2_v ? IM_Data : 32'h0;
      IF_ID_PC4         <= f2_pc + 32'd4;
      IF_ID_Valid       <= f2_v;
      Perf_Fetched      <= Perf_Fetched + {31'h0, f2_v};
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a synchronous memory model
// whose word at byte address a is 32'h1000_0000 + a/4.
module tb_instruction_fetch_unit;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        ID_stall = 1'b0;
  logic        ID_PCSrc = 1'b0;
  logic [31:0] ID_new_PC = 32'h0;
  logic [31:0] IM_Addr;
  logic [31:0] IM_Data = 32'h0;
  logic [31:0] IF_ID_Instruction;
  logic [31:0] IF_ID_PC4;
  logic        IF_ID_Valid;
  logic        Misaligned;
  logic [31:0] Perf_Fetched;
  logic [31:0] Perf_Redirects;

  int passed = 0;
  int total  = 0;

  instruction_fetch_unit dut (
    .Clk(Clk),
    .Rst(Rst),
    .ID_stall(ID_stall),
    .ID_PCSrc(ID_PCSrc),
    .ID_new_PC(ID_new_PC),
    .IM_Addr(IM_Addr),
    .IM_Data(IM_Data),
    .IF_ID_Instruction(IF_ID_Instruction),
    .IF_ID_PC4(IF_ID_PC4),
    .IF_ID_Valid(IF_ID_Valid),
    .Misaligned(Misaligned),
    .Perf_Fetched(Perf_Fetched),
    .Perf_Redirects(Perf_Redirects)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) IM_Data <= 32'h1000_0000 + (IM_Addr >> 2);

  typedef struct {
    logic        stall;
    logic        pcsrc;
    logic [31:0] npc;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        mis;
    logic [31:0] fet;
    logic [31:0] red;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic step(input int idx, input vec_t v);
    ID_stall  = v.stall;
    ID_PCSrc  = v.pcsrc;
    ID_new_PC = v.npc;
    #1;
    chk($sformatf("v%0d addr", idx), IM_Addr, v.addr);
    @(posedge Clk);
    #1;
    chk($sformatf("v%0d valid", idx), {31'h0, IF_ID_Valid}, {31'h0, v.valid});
    chk($sformatf("v%0d instr", idx), IF_ID_Instruction, v.instr);
    chk($sformatf("v%0d pc4", idx), IF_ID_PC4, v.pc4);
    chk($sformatf("v%0d mis", idx), {31'h0, Misaligned}, {31'h0, v.mis});
    chk($sformatf("v%0d fetched", idx), Perf_Fetched, v.fet);
    chk($sformatf("v%0d redirects", idx), Perf_Redirects, v.red);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " addr"}, IM_Addr, 32'h0);
    chk({tag, " valid"}, {31'h0, IF_ID_Valid}, 32'h0);
    chk({tag, " instr"}, IF_ID_Instruction, 32'h0);
    chk({tag, " pc4"}, IF_ID_PC4, 32'h0);
    chk({tag, " mis"}, {31'h0, Misaligned}, 32'h0);
    chk({tag, " fetched"}, Perf_Fetched, 32'h0);
    chk({tag, " redirects"}, Perf_Redirects, 32'h0);
  endtask

  vec_t tbl[17];
  vec_t seq[5];

  initial begin
    //         stall pcsrc npc           addr          v  instr          pc4           m  fet red
    tbl[0]  = '{1'b0, 1'b0, 32'h0,   32'h00, 1'b0, 32'h0,         32'h04, 1'b0, 0, 0};
    tbl[1]  = '{1'b0, 1'b0, 32'h0,   32'h04, 1'b1, 32'h1000_0000, 32'h04, 1'b0, 1, 0};
    tbl[2]  = '{1'b0, 1'b0, 32'h0,   32'h08, 1'b1, 32'h1000_0001, 32'h08, 1'b0, 2, 0};
    tbl[3]  = '{1'b0, 1'b0, 32'h0,   32'h0C, 1'b1, 32'h1000_0002, 32'h0C, 1'b0, 3, 0};
    tbl[4]  = '{1'b1, 1'b0, 32'h0,   32'h0C, 1'b1, 32'h1000_0002, 32'h0C, 1'b0, 3, 0};
    tbl[5]  = '{1'b1, 1'b0, 32'h0,   32'h0C, 1'b1, 32'h1000_0002, 32'h0C, 1'b0, 3, 0};
    tbl[6]  = '{1'b1, 1'b0, 32'h0,   32'h0C, 1'b1, 32'h1000_0002, 32'h0C, 1'b0, 3, 0};
    tbl[7]  = '{1'b0, 1'b0, 32'h0,   32'h10, 1'b1, 32'h1000_0003, 32'h10, 1'b0, 4, 0};
    tbl[8]  = '{1'b0, 1'b0, 32'h0,   32'h14, 1'b1, 32'h1000_0004, 32'h14, 1'b0, 5, 0};
    tbl[9]  = '{1'b1, 1'b1, 32'h80,  32'h14, 1'b1, 32'h1000_0004, 32'h14, 1'b0, 5, 0};
    tbl[10] = '{1'b0, 1'b1, 32'h40,  32'h40, 1'b0, 32'h0,         32'h14, 1'b0, 5, 1};
    tbl[11] = '{1'b0, 1'b0, 32'h0,   32'h44, 1'b1, 32'h1000_0010, 32'h44, 1'b0, 6, 1};
    tbl[12] = '{1'b0, 1'b0, 32'h0,   32'h48, 1'b1, 32'h1000_0011, 32'h48, 1'b0, 7, 1};
    tbl[13] = '{1'b0, 1'b1, 32'h42,  32'h40, 1'b0, 32'h0,         32'h48, 1'b1, 7, 2};
    tbl[14] = '{1'b0, 1'b0, 32'h0,   32'h44, 1'b1, 32'h1000_0010, 32'h44, 1'b1, 8, 2};
    tbl[15] = '{1'b0, 1'b1, 32'h100, 32'h100, 1'b0, 32'h0,        32'h44, 1'b1, 8, 3};
    tbl[16] = '{1'b0, 1'b0, 32'h0,   32'h104, 1'b1, 32'h1000_0040, 32'h104, 1'b1, 9, 3};

    // After a mid-stream reset: stall into an empty pipe, then wrap at the top.
    seq[0] = '{1'b1, 1'b0, 32'h0, 32'h00, 1'b0, 32'h0, 32'h00, 1'b0, 0, 0};
    seq[1] = '{1'b0, 1'b0, 32'h0, 32'h04, 1'b1, 32'h1000_0000, 32'h04, 1'b0, 1, 0};
    seq[2] = '{1'b0, 1'b0, 32'h0, 32'h08, 1'b1, 32'h1000_0001, 32'h08, 1'b0, 2, 0};
    seq[3] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0, 32'h0,
               32'h08, 1'b0, 2, 1};
    seq[4] = '{1'b0, 1'b0, 32'h0, 32'h00, 1'b1, 32'h4FFF_FFFF, 32'h00, 1'b0, 3, 1};

    #3;
    chk_reset("rst0");
    @(posedge Clk);
    #1;
    chk_reset("rst0 held");
    Rst = 1'b1;

    for (int i = 0; i < 17; i++) step(i, tbl[i]);

    ID_stall  = 1'b0;
    ID_PCSrc  = 1'b1;
    ID_new_PC = 32'h200;
    #2;
    Rst = 1'b0;
    #1;
    ID_PCSrc  = 1'b0;
    ID_new_PC = 32'h0;
    #1;
    chk_reset("rst1");
    @(posedge Clk);
    #1;
    chk_reset("rst1 held");
    Rst = 1'b1;

    for (int i = 0; i < 5; i++) step(100 + i, seq[i]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
